out_lane_checker: RTL and testbench

- Single-lane consumer of one TIS core output port, placed directly downstream of the core complex's bottom-row write port.
- Accepts 11-bit signed values over the blocking write/ready handshake and compares each against an expected-stream ROM entry.
- Reports completion, pass/fail, error count, first mismatch index and overflow to the top level (timer stop, LEDs).
- Four instances make up the output side of the design.

---
 rtl/out_lane_checker.sv | 126 ++++++++++++
 tb/tb_out_lane_checker.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/out_lane_checker.sv
// Output-lane checker: accepts signed values from one core output port and
// compares each against an expected-stream ROM, reporting pass/fail status.
module out_lane_checker #(
  parameter int DW    = 11,
  parameter int AW    = 6,
  parameter int DEPTH = 39
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] length,
  output logic [AW-1:0] exp_addr,
  input  logic [DW-1:0] exp_data,
  input  logic          write,
  input  logic [DW-1:0] in_data,
  output logic          wready,
  output logic          complete,
  output logic          pass,
  output logic [AW-1:0] err_count,
  output logic [AW-1:0] first_err,
  output logic          overflow,
  output logic [DW-1:0] last_value
);

  localparam logic [AW-1:0] DEPTH_C = AW'(DEPTH);
  localparam logic [AW-1:0] ONES    = '1;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state, w_next_state;
  logic [AW-1:0] r_len;
  logic [AW-1:0] r_rx_count;
  logic [AW-1:0] r_err_count;
  logic [AW-1:0] r_first_err;
  logic [DW-1:0] r_last_value;
  logic          r_complete;
  logic          r_pass;
  logic          r_overflow;

  logic [AW-1:0] w_len_clamp;
  logic [AW-1:0] w_rx_inc;
  logic [AW-1:0] w_err_next;
  logic          w_mismatch;
  logic          w_xfer;
  logic          w_last_xfer;

  assign w_len_clamp = (length > DEPTH_C) ? DEPTH_C : length;
  assign w_rx_inc    = r_rx_count + 1'b1;
  assign w_mismatch  = (in_data != exp_data);
  assign w_xfer      = write && wready;
  assign w_last_xfer = w_xfer && (w_rx_inc == r_len);
  // Error count saturates rather than wrapping back to a "clean" value.
  assign w_err_next  = (w_mismatch && (r_err_count != ONES)) ? (r_err_count + 1'b1)
                                                             : r_err_count;

  always_comb begin
    w_next_state = r_state;
    wready       = 1'b0;
    case (r_state)
      S_INIT: w_next_state = (w_len_clamp == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        wready = 1'b1;
        if (w_last_xfer) w_next_state = S_DONE;
      end
      S_DONE: wready = 1'b1;
      default: w_next_state = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_INIT;
      r_len        <= '0;
      r_rx_count   <= '0;
      r_err_count  <= '0;
      r_first_err  <= ONES;
      r_last_value <= '0;
      r_complete   <= 1'b0;
      r_pass       <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_INIT: begin
          r_len <= w_len_clamp;
          if (w_len_clamp == '0) begin
            r_complete <= 1'b1;
            r_pass     <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_xfer) begin
            r_last_value <= in_data;
            r_rx_count   <= w_rx_inc;
            r_err_count  <= w_err_next;
            if (w_mismatch && (r_first_err == ONES)) r_first_err <= r_rx_count;
            if (w_last_xfer) begin
              r_complete <= 1'b1;
              r_pass     <= (w_err_next == '0);
            end
          end
        end
        S_DONE: begin
          // Late values are absorbed so the core never stalls; only flagged.
          if (w_xfer) begin
            r_overflow   <= 1'b1;
            r_last_value <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign exp_addr   = r_rx_count;
  assign complete   = r_complete;
  assign pass       = r_pass;
  assign err_count  = r_err_count;
  assign first_err  = r_first_err;
  assign overflow   = r_overflow;
  assign last_value = r_last_value;

endmodule

// File: tb/tb_out_lane_checker.sv
// Bench for out_lane_checker: directed test-plan scenarios plus randomized
// streams, all checked against a stream-level reference model.
module tb_out_lane_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  length = '0;
  logic [5:0]  exp_addr;
  logic [10:0] exp_data;
  logic        write = 1'b0;
  logic [10:0] in_data = '0;
  logic        wready;
  logic        complete;
  logic        pass;
  logic [5:0]  err_count;
  logic [5:0]  first_err;
  logic        overflow;
  logic [10:0] last_value;

  logic [10:0] rom [0:63];
  logic [10:0] q [$];
  int          m_len;
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;

  assign exp_data = rom[exp_addr];

  out_lane_checker dut (
    .clk(clk), .rst(rst), .length(length), .exp_addr(exp_addr),
    .exp_data(exp_data), .write(write), .in_data(in_data), .wready(wready),
    .complete(complete), .pass(pass), .err_count(err_count),
    .first_err(first_err), .overflow(overflow), .last_value(last_value)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Stream-level model: outcome follows from the list of values sent so far.
  task automatic check_all(input string tag);
    int n, nx, errs, first, last;
    n = q.size();
    nx = (n < m_len) ? n : m_len;
    errs = 0;
    first = 63;
    for (int i = 0; i < nx; i++) begin
      if (q[i] !== rom[i]) begin
        if (first == 63) first = i;
        errs++;
      end
    end
    if (errs > 63) errs = 63;
    last = (n > 0) ? int'(q[n-1]) : 0;
    chk({tag, ".wready"},   {31'b0, wready},     1);
    chk({tag, ".complete"}, {31'b0, complete},   (n >= m_len) ? 1 : 0);
    chk({tag, ".pass"},     {31'b0, pass},       ((n >= m_len) && errs == 0) ? 1 : 0);
    chk({tag, ".err"},      {26'b0, err_count},  errs);
    chk({tag, ".first"},    {26'b0, first_err},  first);
    chk({tag, ".ovf"},      {31'b0, overflow},   (n > m_len) ? 1 : 0);
    chk({tag, ".last"},     {21'b0, last_value}, last);
    chk({tag, ".addr"},     {26'b0, exp_addr},   nx);
  endtask

  task automatic do_reset(input int len);
    @(negedge clk);
    rst = 1'b1;
    write = 1'b0;
    length = 6'(len);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_len = (len > 39) ? 39 : len;
    chk("rst.wready",   {31'b0, wready},     0);
    chk("rst.complete", {31'b0, complete},   0);
    chk("rst.pass",     {31'b0, pass},       0);
    chk("rst.ovf",      {31'b0, overflow},   0);
    chk("rst.err",      {26'b0, err_count},  0);
    chk("rst.first",    {26'b0, first_err},  63);
    chk("rst.last",     {21'b0, last_value}, 0);
    chk("rst.addr",     {26'b0, exp_addr},   0);
    @(negedge clk);
    length = 6'($urandom);
    check_all("init_exit");
  endtask

  task automatic send(input logic [10:0] v, input int gap);
    int t;
    repeat (gap) begin
      write = 1'b0;
      @(negedge clk);
      chk("idle.wready", {31'b0, wready}, 1);
    end
    write = 1'b1;
    in_data = v;
    t = 0;
    while (!wready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("send.wready", {31'b0, wready}, 1);
    @(negedge clk);
    write = 1'b0;
    q.push_back(v);
    check_all("xfer");
  endtask

  initial begin
    int c0, lq, n;
    logic [10:0] v;

    // back-to-back stream, all matching
    rom[0] = 11'd5; rom[1] = 11'h7F9; rom[2] = 11'd1023;
    do_reset(3);
    c0 = cyc;
    send(11'd5, 0); send(11'h7F9, 0); send(11'd1023, 0);
    chk("t1.cycles", cyc - c0, 3);
    chk("t1.pass", {31'b0, pass}, 1);
    chk("t1.first", {26'b0, first_err}, 63);
    chk("t1.last", {21'b0, last_value}, 1023);

    // gaps and two mismatches
    rom[0] = 11'd1; rom[1] = 11'd2; rom[2] = 11'd3; rom[3] = 11'd4;
    do_reset(4);
    send(11'd1, 0); send(11'd9, 1); send(11'd3, 2); send(11'd0, 3);
    chk("t2.err", {26'b0, err_count}, 2);
    chk("t2.first", {26'b0, first_err}, 1);
    chk("t2.pass", {31'b0, pass}, 0);
    chk("t2.complete", {31'b0, complete}, 1);

    // zero length, then an overflow write
    do_reset(0);
    chk("t3.pass", {31'b0, pass}, 1);
    send(11'd12, 0);
    chk("t3.ovf", {31'b0, overflow}, 1);
    chk("t3.last", {21'b0, last_value}, 12);
    chk("t3.err", {26'b0, err_count}, 0);

    // length clamp
    for (int i = 0; i < 64; i++) rom[i] = 11'($urandom);
    do_reset(50);
    for (int i = 0; i < 38; i++) send(rom[i], 0);
    chk("t4.notyet", {31'b0, complete}, 0);
    send(rom[38], 0);
    chk("t4.complete", {31'b0, complete}, 1);
    send(11'd77, 0);
    chk("t4.ovf", {31'b0, overflow}, 1);
    chk("t4.pass", {31'b0, pass}, 1);

    // mid-stream reset, then a clean stream
    for (int i = 0; i < 5; i++) rom[i] = 11'($urandom);
    do_reset(5);
    send(rom[0], 0); send(11'(rom[1] ^ 11'h1), 0);
    do_reset(5);
    for (int i = 0; i < 5; i++) send(rom[i], 0);
    chk("t5.pass", {31'b0, pass}, 1);

    // full-width signed compare
    rom[0] = 11'h7FF; rom[1] = 11'h7FF;
    do_reset(2);
    send(11'h3FF, 0);
    chk("t6.err_a", {26'b0, err_count}, 1);
    send(11'h7FF, 1);
    chk("t6.err_b", {26'b0, err_count}, 1);
    chk("t6.first", {26'b0, first_err}, 0);

    // randomized streams
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 64; i++) rom[i] = 11'($urandom);
      n = $urandom_range(0, 45);
      lq = (n > 39) ? 39 : n;
      do_reset(n);
      for (int i = 0; i < lq + int'($urandom_range(0, 2)); i++) begin
        v = (i < lq && $urandom_range(0, 3) != 0) ? rom[i] : 11'($urandom);
        send(v, $urandom_range(0, 2));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
